imm_ext_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the ID stage of the five-stage pipeline.

---
 rtl/imm_ext_pipe.sv | 117 +++++++++++
 tb/tb_imm_ext_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate generator for ID: sign/zero/upper/branch extension of an IN_W-bit field to OUT_W bits.
// Latency: one clock from acceptance to out_* when the output register is free, otherwise via the skid.
// Backpressure: one-entry skid absorbs a stall; in_ready is a registered flag, independent of out_ready.
module imm_ext_pipe #(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,   // must be >= IN_W + BR_SHIFT
   parameter int BR_SHIFT = 2,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag
);

   localparam int EXT_W = OUT_W - IN_W;

   typedef enum logic [1:0] {
      MODE_SIGN   = 2'd0,
      MODE_ZERO   = 2'd1,
      MODE_UPPER  = 2'd2,
      MODE_BRANCH = 2'd3
   } mode_e;

   // Extended immediate travels with its tag as one word through both registers.
   typedef struct packed {
      logic [OUT_W-1:0] imm;
      logic [TAG_W-1:0] tag;
   } item_t;

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] uext;
   logic [OUT_W-1:0] bext;
   item_t            new_item;

   logic  skid_full;
   item_t skid;

   logic accept;
   logic out_free;
   logic load_from_skid;
   logic load_from_in;
   logic to_skid;

   // Extension is done before storage so the skid holds final values.
   always_comb begin
      sext         = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
      zext         = {{EXT_W{1'b0}}, in_imm};
      uext         = {in_imm, {EXT_W{1'b0}}};
      bext         = sext << BR_SHIFT;
      new_item.tag = in_tag;
      case (mode_e'(in_mode))
         MODE_SIGN:   new_item.imm = sext;
         MODE_ZERO:   new_item.imm = zext;
         MODE_UPPER:  new_item.imm = uext;
         MODE_BRANCH: new_item.imm = bext;
         default:     new_item.imm = sext;
      endcase
   end

   // in_ready only looks at rst and the registered skid flag, never at out_ready.
   assign in_ready = !rst && !skid_full;

   // Handshake decode: the output register is free when empty or draining this edge.
   always_comb begin
      accept         = in_valid && in_ready;
      out_free       = !out_valid || out_ready;
      load_from_skid = out_free && skid_full;
      load_from_in   = out_free && !skid_full && accept;
      to_skid        = !out_free && accept;
   end

   // Output register: refilled from the skid first (older item), else from the input.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_imm   <= '0;
         out_tag   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (out_free) begin
         out_valid <= skid_full || accept;
         if (load_from_skid) begin
            out_imm <= skid.imm;
            out_tag <= skid.tag;
         end else if (load_from_in) begin
            out_imm <= new_item.imm;
            out_tag <= new_item.tag;
         end
      end
   end

   // Skid register: catches an item arriving while the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_full <= 1'b0;
         skid      <= '0;
      end else if (flush) begin
         skid_full <= 1'b0;
      end else if (load_from_skid) begin
         skid_full <= 1'b0;
      end else if (to_skid) begin
         skid_full <= 1'b1;
         skid      <= new_item;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed cases with literal values plus randomized traffic.
// Reference is a two-deep in-order queue with flush/reset clearing and arithmetic extension.
// Compare process checks outputs every cycle against that queue.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_imm;
   logic [4:0]  out_tag;

   imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference extension from plain integer arithmetic.
   function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic [1:0] mode);
      longint s;
      s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
      case (mode)
         2'd0:    return 32'(s);
         2'd1:    return 32'(longint'(imm));
         2'd2:    return 32'(longint'(imm) * 65536);
         default: return 32'(s * 4);
      endcase
   endfunction

   typedef struct {
      logic [31:0] imm;
      logic [4:0]  tag;
   } item_t;

   // Behavioural model: everything accepted and not yet delivered, oldest first (at most 2).
   item_t q[$];
   logic  clr = 1'b1;   // outputs hold reset zeros until first load

   always @(posedge clk) begin
      item_t it;
      bit    rdy;
      if (rst) begin
         q.delete();
         clr = 1'b1;
      end else if (flush) begin
         q.delete();
      end else begin
         rdy = (q.size() < 2);
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (in_valid && rdy) begin
            it.imm = ext_ref(in_imm, in_mode);
            it.tag = in_tag;
            q.push_back(it);
         end
         if (q.size() > 0) clr = 1'b0;
      end
   end

   // Record what actually leaves the DUT, with the cycle it left.
   logic [4:0] recv[$];
   int         recv_cyc[$];
   int         cyc = 0;

   always @(posedge clk) begin
      cyc++;
      if (!rst && !flush && out_valid && out_ready) begin
         recv.push_back(out_tag);
         recv_cyc.push_back(cyc);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("in_ready", in_ready, (!rst && q.size() < 2));
      chk("out_valid", out_valid, (q.size() > 0));
      if (q.size() > 0) begin
         chk("out_imm", out_imm, q[0].imm);
         chk("out_tag", out_tag, q[0].tag);
      end else if (clr) begin
         chk("out_imm_rst", out_imm, 32'h0);
         chk("out_tag_rst", out_tag, 32'h0);
      end
   end

   int ordy_mode = 0;   // 0 fixed, 1 toggle, 2 random

   task automatic tick();
      @(negedge clk);
      #1;
      case (ordy_mode)
         1:       out_ready = !out_ready;
         2:       out_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   // Offer one item, holding it until the DUT takes it (bounded).
   task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
      for (int k = 0; k < 40 && !acc; k++) begin
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout tag=%0d actual=not_accepted expected=accepted", tag);
      end
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", out_valid, 32'h0);
      chk("rst_out_imm", out_imm, 32'h0);
      chk("rst_out_tag", out_tag, 32'h0);
      chk("rst_in_ready", in_ready, 32'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 32'h1);

      // Extension modes, out_ready held high, latency one
      out_ready = 1'b1;
      send(16'h0008, 2'd0, 5'd1);
      chk("sign_0008", out_imm, 32'h00000008);
      chk("sign_0008_vld", out_valid, 32'h1);
      send(16'hFF38, 2'd0, 5'd2);
      chk("sign_FF38", out_imm, 32'hFFFFFF38);
      chk("sign_FF38_tag", out_tag, 32'd2);
      send(16'hFF38, 2'd1, 5'd3);
      chk("zero_FF38", out_imm, 32'h0000FF38);
      send(16'h1234, 2'd2, 5'd4);
      chk("upper_1234", out_imm, 32'h12340000);
      send(16'hFFFF, 2'd3, 5'd5);
      chk("branch_FFFF", out_imm, 32'hFFFFFFFC);
      send(16'h7FFF, 2'd3, 5'd6);
      chk("branch_7FFF", out_imm, 32'h0001FFFC);
      tick();
      tick();

      // Back-to-back stream with out_ready toggling
      recv.delete();
      recv_cyc.delete();
      out_ready = 1'b1;
      ordy_mode = 1;
      for (int t = 0; t < 8; t++) send(16'($urandom), 2'($urandom_range(0, 3)), 5'(t));
      ordy_mode = 0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("stream_count", recv.size(), 32'd8);
      for (int i = 0; i < 8 && i < recv.size(); i++) chk("stream_order", recv[i], 32'(i));

      // Stall: two accepted, third held upstream, then consecutive exits
      recv.delete();
      recv_cyc.delete();
      out_ready = 1'b0;
      send(16'h0101, 2'd0, 5'd9);
      send(16'h0202, 2'd1, 5'd10);
      in_valid = 1'b1;
      in_imm   = 16'h0303;
      in_mode  = 2'd2;
      in_tag   = 5'd11;
      tick();
      chk("stall_in_ready", in_ready, 32'h0);
      chk("stall_out_tag", out_tag, 32'd9);
      tick();
      chk("stall_hold_imm", out_imm, 32'h00000101);
      out_ready = 1'b1;
      send(16'h0303, 2'd2, 5'd11);
      repeat (3) tick();
      chk("stall_count", recv.size(), 32'd3);
      if (recv.size() == 3) begin
         chk("stall_tag0", recv[0], 32'd9);
         chk("stall_tag1", recv[1], 32'd10);
         chk("stall_tag2", recv[2], 32'd11);
         chk("stall_gap01", recv_cyc[1] - recv_cyc[0], 32'd1);
         chk("stall_gap12", recv_cyc[2] - recv_cyc[1], 32'd1);
      end

      // Flush with the skid full and an item on offer
      recv.delete();
      recv_cyc.delete();
      out_ready = 1'b0;
      send(16'h1111, 2'd0, 5'd20);
      send(16'h2222, 2'd0, 5'd21);
      in_valid = 1'b1;
      in_imm   = 16'h3333;
      in_tag   = 5'd22;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 32'h0);
      chk("flush_in_ready", in_ready, 32'h1);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("flush_nothing_out", recv.size(), 32'd0);
      send(16'h0044, 2'd1, 5'd23);
      tick();
      chk("flush_next_count", recv.size(), 32'd1);
      if (recv.size() == 1) chk("flush_next_tag", recv[0], 32'd23);

      // Reset mid-stream with the skid full
      out_ready = 1'b0;
      send(16'h5555, 2'd1, 5'd24);
      send(16'h6666, 2'd1, 5'd25);
      in_valid = 1'b1;
      in_tag   = 5'd26;
      rst      = 1'b1;
      #1;
      chk("midrst_in_ready_during", in_ready, 32'h0);
      tick();
      chk("midrst_out_valid", out_valid, 32'h0);
      chk("midrst_out_imm", out_imm, 32'h0);
      chk("midrst_out_tag", out_tag, 32'h0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("midrst_in_ready_after", in_ready, 32'h1);
      out_ready = 1'b1;
      send(16'h8001, 2'd0, 5'd27);
      chk("midrst_first_vld", out_valid, 32'h1);
      chk("midrst_first_imm", out_imm, 32'hFFFF8001);
      chk("midrst_first_tag", out_tag, 32'd27);

      // Randomized traffic with occasional flush and reset
      ordy_mode = 2;
      for (int n = 0; n < 3000; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_imm   = 16'($urandom);
         in_mode  = 2'($urandom_range(0, 3));
         in_tag   = 5'($urandom);
         flush    = ($urandom_range(0, 31) == 0);
         rst      = ($urandom_range(0, 299) == 0);
         tick();
      end
      ordy_mode = 0;
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
